// File: rtl/clk_period_meter.sv
// Measures rise-to-rise period and high time of an asynchronous slow signal in
// sys_clk cycles, with power-of-two detection and divider speed_sel estimate.
module clk_period_meter #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic                     meas_en,
   input  logic                     sig_in,
   output logic [CNT_W-1:0]         period,
   output logic [CNT_W-1:0]         high_time,
   output logic                     meas_valid,
   output logic                     timeout,
   output logic                     pow2,
   output logic [$clog2(CNT_W)-1:0] speed_est
);

   localparam int unsigned SE_W = $clog2(CNT_W);

   typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

   state_t                 state, state_nx;
   logic [SYNC_STAGES-1:0] sync;
   logic                   sig_s, sig_d, rise, fall;
   logic [CNT_W-1:0]       cnt, hcnt, hi_lat;
   logic                   hi_done;
   logic                   cnt_max, cnt_pow2;
   logic [SE_W-1:0]        cnt_log2;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync  <= '0;
         sig_d <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], sig_in};
         sig_d <= sig_s;
      end
   end

   assign sig_s = sync[SYNC_STAGES-1];
   assign rise  = sig_s & ~sig_d;
   assign fall  = ~sig_s & sig_d;

   assign cnt_max  = &cnt;
   assign cnt_pow2 = (cnt != '0) && ((cnt & (cnt - CNT_W'(1))) == '0);

   // Index of the highest set bit; only meaningful when cnt is a power of two.
   always_comb begin
      cnt_log2 = '0;
      for (int unsigned i = 0; i < CNT_W; i++) begin
         if (cnt[i]) cnt_log2 = SE_W'(i);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (!meas_en) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    state_nx = ARM;
            ARM:     if (rise) state_nx = MEAS;
            MEAS:    if (!rise && cnt_max) state_nx = ARM;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt        <= '0;
         hcnt       <= '0;
         hi_lat     <= '0;
         hi_done    <= 1'b0;
         period     <= '0;
         high_time  <= '0;
         meas_valid <= 1'b0;
         timeout    <= 1'b0;
         pow2       <= 1'b0;
         speed_est  <= '0;
      end else begin
         meas_valid <= 1'b0;
         if (meas_en) begin
            case (state)
               ARM: begin
                  if (rise) begin
                     cnt     <= CNT_W'(1);
                     hcnt    <= CNT_W'(1);
                     hi_done <= 1'b0;
                  end
               end
               MEAS: begin
                  // A rise on the terminal count still completes the measurement.
                  if (rise) begin
                     period     <= cnt;
                     high_time  <= hi_lat;
                     pow2       <= cnt_pow2;
                     speed_est  <= cnt_pow2 ? cnt_log2 - SE_W'(1) : '0;
                     meas_valid <= 1'b1;
                     timeout    <= 1'b0;
                     cnt        <= CNT_W'(1);
                     hcnt       <= CNT_W'(1);
                     hi_done    <= 1'b0;
                  end else if (cnt_max) begin
                     timeout <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                     if (sig_s && !hi_done) hcnt <= hcnt + CNT_W'(1);
                     if (fall) begin
                        hi_lat  <= hcnt;
                        hi_done <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized scoreboard bench for clk_period_meter: an edge-timestamp model
// predicts each measurement; a monitor checks every cycle and every valid pulse.
module tb_clk_period_meter;

   localparam int CW   = 8;
   localparam int SS   = 2;
   localparam int SEW  = $clog2(CW);
   localparam int MAXC = (1 << CW) - 1;

   logic           sys_clk = 1'b0;
   logic           sys_rst, meas_en, sig_in;
   logic [CW-1:0]  period, high_time;
   logic           meas_valid, timeout, pow2;
   logic [SEW-1:0] speed_est;

   clk_period_meter #(.CNT_W(CW), .SYNC_STAGES(SS)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .meas_en   (meas_en),
      .sig_in    (sig_in),
      .period    (period),
      .high_time (high_time),
      .meas_valid(meas_valid),
      .timeout   (timeout),
      .pow2      (pow2),
      .speed_est (speed_est)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   typedef struct {int edge_n; int per; int hi; int pw; int sp;} exp_t;
   exp_t q[$];

   typedef enum {OFF, HUNT, RUN} mode_t;
   mode_t mode = OFF;
   int    ref_t, fall_t;
   bit    h1, h2, h3;
   int    e_per, e_hi, e_pw, e_sp, e_to;
   bit    done = 1'b0;
   int    n_pass = 0, n_total = 0;

   function automatic void pow2_of(input int p, output int pw, output int sp);
      pw = 0;
      sp = 0;
      for (int k = 1; k < CW; k++) begin
         if (p == (1 << k)) begin
            pw = 1;
            sp = k - 1;
         end
      end
   endfunction

   // Predict the effect of the edge that will sample these inputs, then apply them.
   // h1..h3 hold the values the two synchronizer stages and the delay flop carry.
   task automatic drive(input bit s, input bit e, input bit r);
      int m;
      bit rs, fl;
      m  = cyc + 1;
      rs = h2 & ~h3;
      fl = ~h2 & h3;
      if (r) begin
         mode  = OFF;
         e_per = 0; e_hi = 0; e_pw = 0; e_sp = 0; e_to = 0;
         h1 = 0; h2 = 0; h3 = 0;
      end else begin
         if (!e) mode = OFF;
         else if (mode == OFF) mode = HUNT;
         else if (mode == HUNT) begin
            if (rs) begin
               ref_t = m; fall_t = m; mode = RUN;
            end
         end else begin
            if (rs) begin
               e_per = m - ref_t;
               e_hi  = fall_t - ref_t;
               pow2_of(e_per, e_pw, e_sp);
               e_to  = 0;
               q.push_back('{m, e_per, e_hi, e_pw, e_sp});
               ref_t = m; fall_t = m;
            end else if (m - ref_t == MAXC) begin
               e_to = 1;
               mode = HUNT;
            end else if (fl) begin
               fall_t = m;
            end
         end
         h3 = h2; h2 = h1; h1 = s;
      end
      sig_in  = s;
      meas_en = e;
      sys_rst = r;
      @(negedge sys_clk);
   endtask

   task automatic wave(input int p, input int h, input int n, input bit e);
      for (int i = 0; i < n; i++)
         for (int c = 0; c < p; c++) drive(c < h, e, 1'b0);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
   endtask

   initial begin
      int p, h;
      repeat (3) drive(1'b0, 1'b0, 1'b1);
      repeat (4) drive(1'b0, 1'b1, 1'b0);
      wave(8, 4, 10, 1'b1);
      wave(12, 3, 8, 1'b1);
      for (int seg = 0; seg < 25; seg++) begin
         p = $urandom_range(40, 2);
         h = $urandom_range(p - 1, 1);
         wave(p, h, $urandom_range(5, 2), 1'b1);
         if ($urandom_range(4, 0) == 0) wave(p, h, 1, 1'b0);
      end
      // timeout after a single rise, then recovery
      wave(8, 4, 3, 1'b1);
      repeat (4) drive(1'b1, 1'b1, 1'b0);
      repeat (300) drive(1'b0, 1'b1, 1'b0);
      wave(8, 4, 4, 1'b1);
      // largest measurable period, then one just beyond it
      wave(255, 2, 3, 1'b1);
      wave(256, 2, 2, 1'b1);
      wave(8, 4, 3, 1'b1);
      // enable dropped mid-period
      wave(8, 4, 3, 1'b1);
      repeat (3) drive(1'b1, 1'b0, 1'b0);
      wave(8, 4, 4, 1'b1);
      // reset mid-measurement
      drive(1'b1, 1'b1, 1'b1);
      wave(8, 4, 4, 1'b1);
      // enable falls on the same edge the rise is acted on
      repeat (6) drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      repeat (3) drive(1'b1, 1'b0, 1'b0);
      wave(8, 4, 4, 1'b1);
      repeat (5) drive(1'b0, 1'b1, 1'b0);
      done = 1'b1;
   end

   initial begin
      while (!done) begin
         @(posedge sys_clk);
         #1;
         chk("period", int'(period), e_per);
         chk("high_time", int'(high_time), e_hi);
         chk("timeout", int'(timeout), e_to);
         chk("pow2", int'(pow2), e_pw);
         chk("speed_est", int'(speed_est), e_sp);
         if (q.size() > 0 && q[0].edge_n == cyc) begin
            chk("meas_valid", int'(meas_valid), 1);
            chk("sb_period", int'(period), q[0].per);
            chk("sb_high_time", int'(high_time), q[0].hi);
            chk("sb_pow2", int'(pow2), q[0].pw);
            chk("sb_speed_est", int'(speed_est), q[0].sp);
            void'(q.pop_front());
         end else begin
            chk("no_valid", int'(meas_valid), 0);
         end
      end
      chk("queue_empty", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
